// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment scanner:
//   - SEG_A..SEG_G, SEG_DP : bit positions inside the 8-bit segment byte
//                            {dp,g,f,e,d,c,b,a}
//   - SEG_DECODE           : hex nibble -> a..g pattern (active-high)
//   - scan_state_e         : scanner FSM states
//   - seg_pattern()        : builds the full active-high segment byte
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Index 0 is the leftmost entry; lowercase b and d avoid clashing with 8 and 0.
  localparam logic [6:0] SEG_DECODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  function automatic logic [7:0] seg_pattern(input logic [3:0] nib, input logic dp);
    logic [7:0] s;
    s               = 8'h00;
    s[SEG_G:SEG_A]  = SEG_DECODE[nib];
    s[SEG_DP]       = dp;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clock_in domain through a flop chain
// and emits a one-cycle pulse on each rising edge of the synchronised level.
// Usable for the divided scan clock or for debounced push buttons.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth (>= 2)
// Ports:
//   clock_in : system clock
//   reset    : synchronous, active-high reset (clears chain and edge register)
//   async_in : level to synchronise (treated as data)
//   rise     : high for exactly one cycle per rising edge of the synced level
// -----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational so the consumer sees the tick in the cycle right after the
  // last synchronizer stage goes high.
  assign rise = sync_q[SYNC_STAGES-1] & ~level_d;

endmodule

// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
// Multiplexed seven-segment driver. The slow scan clock from the clock divider
// is sampled as data; each rising edge becomes a scan tick that moves the
// display to the next digit through a guard blank interval (anti-ghosting).
//
// Parameters:
//   NUM_DIGITS   : number of digits (2..8)
//   BLANK_CYCLES : counter load for the guard interval; BLANK lasts
//                  BLANK_CYCLES+1 cycles (exactly 1 when 0)
//   ACTIVE_LOW   : 1 = pins are active-low, 0 = active-high
//   SYNC_STAGES  : scan_clk synchronizer depth (>= 2)
// Ports:
//   clock_in  : system clock (only clock)
//   reset     : synchronous, active-high reset
//   scan_clk  : divided clock level, sampled as data
//   enable    : 0 forces all anodes inactive, scanning continues
//   digits    : hex nibbles, digit i = digits[4i+3:4i]
//   dp_in     : decimal point per digit
//   anode_out : one-hot digit select, pin polarity
//   seg_out   : {dp,g,f,e,d,c,b,a}, pin polarity
//   digit_idx : digit currently selected by the FSM (debug)
// Build option:
//   SEVEN_SEG_LZ_BLANK_EN : leading-zero blanking (digit 0 always shown,
//                           dp_in[i]=1 keeps digit i lit)
// -----------------------------------------------------------------------------
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          clock_in,
  input  logic                          reset,
  input  logic                          scan_clk,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [NUM_DIGITS-1:0]         anode_out,
  output logic [7:0]                    seg_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  // "Off" pattern at the pins; XOR with it also applies the pin polarity.
  localparam logic [7:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  logic                  scan_tick;
  scan_state_e           state;
  logic [CNT_W-1:0]      blank_cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  first_pass;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] anode_onehot;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_scan_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in (scan_clk),
    .rise     (scan_tick)
  );

  // Scan FSM. Ticks arriving in BLANK are simply ignored (dropped).
  // first_pass keeps digit 0 on the very first exit from BLANK after reset.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= BLANK;
      blank_cnt  <= '0;
      idx_q      <= '0;
      first_pass <= 1'b1;
    end else begin
      case (state)
        SHOW: begin
          if (scan_tick) begin
            state     <= BLANK;
            blank_cnt <= CNT_LOAD;
          end
        end
        BLANK: begin
          if (blank_cnt == '0) begin
            state      <= SHOW;
            first_pass <= 1'b0;
            if (!first_pass) begin
              idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
          end else begin
            blank_cnt <= blank_cnt - 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  // Select the nibble and decimal point for the current digit.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = digits[4*i +: 4];
        cur_dp  = dp_in[i];
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // Walk from the most significant digit down; upper_zero stays set while
  // every digit seen so far (inclusive) is zero. Digit 0 is never examined.
  logic upper_zero;
  always_comb begin
    lz_blank   = 1'b0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (digits[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        lz_blank = upper_zero & ~dp_in[i];
      end
    end
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign anode_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;

  // Output register: pins follow the FSM state one cycle later.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      anode_out <= AN_OFF;
      seg_out   <= SEG_OFF;
    end else begin
      if ((state == SHOW) && enable && !lz_blank) begin
        anode_out <= anode_onehot ^ AN_OFF;
      end else begin
        anode_out <= AN_OFF;
      end
      if (state == SHOW) begin
        seg_out <= seg_pattern(cur_nib, cur_dp) ^ SEG_OFF;
      end else begin
        seg_out <= SEG_OFF;
      end
    end
  end

  assign digit_idx = idx_q;

endmodule
